// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, lane sizes
// and the request decode used to steer lane extraction and sub-word merge.
package load_store_unit_pkg;

    localparam int unsigned LSU_ADDR_W = 32;
    localparam int unsigned LSU_DATA_W = 32;
    localparam int unsigned LANE_W     = 8;
    localparam int unsigned HALF_W     = 16;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WR     = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    typedef struct packed {
        lsu_size_t  size;
        logic       sign_ext;
        logic [1:0] offset;
    } lane_ctrl_t;

    // Unsupported encodings fall through to a plain word access.
    function automatic lane_ctrl_t decode_lane_ctrl(input logic       we,
                                                    input logic [2:0] funct3,
                                                    input logic [1:0] offset);
        lane_ctrl_t c;
        c.offset   = offset;
        c.sign_ext = 1'b0;
        c.size     = SZ_W;
        if (we) begin
            case (funct3)
                F3_B:    c.size = SZ_B;
                F3_H:    c.size = SZ_H;
                F3_W:    c.size = SZ_W;
                default: c.size = SZ_W;
            endcase
        end else begin
            case (funct3)
                F3_B:    begin c.size = SZ_B; c.sign_ext = 1'b1; end
                F3_BU:   c.size = SZ_B;
                F3_H:    begin c.size = SZ_H; c.sign_ext = 1'b1; end
                F3_HU:   c.size = SZ_H;
                F3_W:    c.size = SZ_W;
                default: c.size = SZ_W;
            endcase
        end
        return c;
    endfunction

    function automatic logic is_misaligned(input lane_ctrl_t c);
        return ((c.size == SZ_H) && c.offset[0]) ||
               ((c.size == SZ_W) && (c.offset != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane steering: extracts and extends a byte/halfword from a read word,
// and merges sub-word store data into a read word for read-modify-write.
module load_store_unit_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [1:0]            offset,
    input  logic [LSU_DATA_W-1:0] rdata,
    input  logic [LSU_DATA_W-1:0] wdata,
    output logic [LSU_DATA_W-1:0] load_word_c,
    output logic [LSU_DATA_W-1:0] store_word_c
);

    lsu_size_t         sz;
    logic [LANE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;

    assign sz = lsu_size_t'(size);

    always_comb begin
        byte_v       = rdata[7:0];
        half_v       = offset[1] ? rdata[31:16] : rdata[15:0];
        load_word_c  = rdata;
        store_word_c = wdata;

        case (offset)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase

        case (sz)
            SZ_B: begin
                load_word_c  = {{(LSU_DATA_W - LANE_W){sign_ext & byte_v[LANE_W-1]}}, byte_v};
                store_word_c = rdata;
                case (offset)
                    2'd0:    store_word_c[7:0]   = wdata[7:0];
                    2'd1:    store_word_c[15:8]  = wdata[7:0];
                    2'd2:    store_word_c[23:16] = wdata[7:0];
                    default: store_word_c[31:24] = wdata[7:0];
                endcase
            end
            SZ_H: begin
                load_word_c  = {{(LSU_DATA_W - HALF_W){sign_ext & half_v[HALF_W-1]}}, half_v};
                store_word_c = rdata;
                if (offset[1]) begin
                    store_word_c[31:16] = wdata[15:0];
                end else begin
                    store_word_c[15:0] = wdata[15:0];
                end
            end
            default: begin
                load_word_c  = rdata;
                store_word_c = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: MEM-stage initiator for a word-wide data memory with sub-word
// loads/stores (RMW) and variable-latency ack. Optional macro: LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W,
    parameter int unsigned DATA_W = LSU_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_err_o,
    output logic              busy_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    lsu_state_t        state_q, state_d;
    lane_ctrl_t        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] st_data_q, st_data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    lane_ctrl_t        req_ctrl_c;
    logic              misalign_c;
    logic [DATA_W-1:0] load_word_c;
    logic [DATA_W-1:0] store_word_c;

    assign req_ctrl_c = decode_lane_ctrl(req_we_i, req_funct3_i, req_addr_i[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_c = is_misaligned(req_ctrl_c);
`else
    assign misalign_c = 1'b0;
`endif

    load_store_unit_lane_align u_lane_align (
        .size         (ctrl_q.size),
        .sign_ext     (ctrl_q.sign_ext),
        .offset       (ctrl_q.offset),
        .rdata        (mem_rdata_i),
        .wdata        (st_data_q),
        .load_word_c  (load_word_c),
        .store_word_c (store_word_c)
    );

    // Next-state and next-output logic; strobes are derived from the state being entered.
    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        st_data_d    = st_data_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_data_d  = resp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && ready_q) begin
                    ctrl_d     = req_ctrl_c;
                    st_data_d  = req_wdata_i;
                    mem_addr_d = {req_addr_i[ADDR_W-1:2], 2'b00};
                    if (misalign_c) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = '0;
                    end else if (!req_we_i) begin
                        state_d  = ST_RD;
                        mem_re_d = 1'b1;
                    end else if (req_ctrl_c.size == SZ_W) begin
                        state_d     = ST_WR;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = req_wdata_i;
                    end else begin
                        state_d  = ST_RMW_RD;
                        mem_re_d = 1'b1;
                    end
                end
            end
            ST_RD: begin
                if (mem_ack_i) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = load_word_c;
                end else begin
                    mem_re_d = 1'b1;
                end
            end
            ST_RMW_RD: begin
                if (mem_ack_i) begin
                    state_d     = ST_WR;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = store_word_c;
                end else begin
                    mem_re_d = 1'b1;
                end
            end
            ST_WR: begin
                if (mem_ack_i) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = '0;
                end else begin
                    mem_we_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // Reset abandons any in-flight access and drops the strobes immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            ctrl_q       <= '0;
            st_data_q    <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            st_data_q    <= st_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready_o  = ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;
    assign busy_o       = busy_q;
    assign mem_re_o     = mem_re_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word memory responder with programmable ack delay,
// hand-computed expected results for loads, sub-word stores, latency, reset and handshake.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic        busy_o;
    logic        mem_re_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    logic [31:0] mem [0:63];
    int ack_delay = 0;
    int wait_cnt = 0;
    int reads = 0, writes = 0, re_cycles = 0, we_cycles = 0;
    int overlap = 0, unstable = 0, busy_gap = 0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_wdata = '0, prev_addr = '0;

    int n_cmp = 0;
    int n_err = 0;

    load_store_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .resp_err_o   (resp_err_o),
        .busy_o       (busy_o),
        .mem_re_o     (mem_re_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request: wait for ready, accept, then wait (bounded) for resp_valid.
    // lat counts cycles from the accept cycle to the response cycle inclusive.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat,
                          output logic [31:0] data, output logic err);
        bit got_resp;
        int guard;
        lat = 0; data = '0; err = 1'b0; got_resp = 0; guard = 0;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
        req_addr_i = addr; req_wdata_i = wdata;
        while (!req_ready_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 50) chk_eq("accept_timeout", 32'(guard), 32'd0);
        lat = 1;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            lat++;
            @(negedge clk_i);
            if (resp_valid_o) begin
                got_resp = 1;
                data = resp_data_o;
                err = resp_err_o;
                break;
            end
            if (!busy_o) busy_gap++;
            @(posedge clk_i);
        end
        if (!got_resp) chk_eq("resp_timeout", 32'(got_resp), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] d;
        logic e;
        int r0, w0, rc0, wc0, resp_cnt, early_ready;
        bit resp_seen;

        rst_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b0;
        req_addr_i = '0; req_wdata_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[4]  = 32'h8000_00F0;
        mem[8]  = 32'h1122_3344;
        mem[12] = 32'h0000_0000;

        // Memory responder: acks after ack_delay waiting cycles, records strobe behaviour.
        fork
            forever begin
                @(negedge clk_i);
                if (mem_re_o && mem_we_o) overlap++;
                if (mem_re_o) re_cycles++;
                if (mem_we_o) we_cycles++;
                if (mem_we_o && prev_we && (mem_wdata_o != prev_wdata || mem_addr_o != prev_addr))
                    unstable++;
                prev_we = mem_we_o; prev_wdata = mem_wdata_o; prev_addr = mem_addr_o;
                if ((mem_re_o || mem_we_o) && rst_i) begin
                    if (wait_cnt >= ack_delay) begin
                        mem_ack_i = 1'b1;
                        mem_rdata_i = mem[mem_addr_o[7:2]];
                        if (mem_we_o) begin
                            mem[mem_addr_o[7:2]] = mem_wdata_o;
                            writes++;
                        end else begin
                            reads++;
                        end
                        wait_cnt = 0;
                    end else begin
                        mem_ack_i = 1'b0;
                        mem_rdata_i = 32'hBAD0_BAD0;
                        wait_cnt++;
                    end
                end else begin
                    mem_ack_i = 1'b0;
                    mem_rdata_i = 32'hBAD0_BAD0;
                    wait_cnt = 0;
                end
            end
        join_none

        repeat (2) @(negedge clk_i);
        chk_eq("rst_ready",  32'(req_ready_o),  32'd0);
        chk_eq("rst_busy",   32'(busy_o),       32'd0);
        chk_eq("rst_re",     32'(mem_re_o),     32'd0);
        chk_eq("rst_we",     32'(mem_we_o),     32'd0);
        chk_eq("rst_rvalid", 32'(resp_valid_o), 32'd0);
        chk_eq("rst_rdata",  resp_data_o,       32'd0);
        chk_eq("rst_err",    32'(resp_err_o),   32'd0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 chk_eq("rel_ready", 32'(req_ready_o), 32'd1);

        // Sub-word loads from 0x8000_00F0 at 0x10
        do_req(1'b0, 3'b000, 32'h10, '0, lat, d, e);
        chk_eq("lb_10", d, 32'hFFFF_FFF0);
        chk_eq("lb_lat", 32'(lat), 32'd3);
        do_req(1'b0, 3'b100, 32'h10, '0, lat, d, e);
        chk_eq("lbu_10", d, 32'h0000_00F0);
        do_req(1'b0, 3'b001, 32'h12, '0, lat, d, e);
        chk_eq("lh_12", d, 32'hFFFF_8000);
        do_req(1'b0, 3'b101, 32'h12, '0, lat, d, e);
        chk_eq("lhu_12", d, 32'h0000_8000);
        do_req(1'b0, 3'b000, 32'h13, '0, lat, d, e);
        chk_eq("lb_13", d, 32'hFFFF_FF80);
        do_req(1'b0, 3'b101, 32'h10, '0, lat, d, e);
        chk_eq("lhu_10", d, 32'h0000_00F0);
        do_req(1'b0, 3'b010, 32'h10, '0, lat, d, e);
        chk_eq("lw_10", d, 32'h8000_00F0);
        chk_eq("lw_lat", 32'(lat), 32'd3);
        chk_eq("lw_err", 32'(e), 32'd0);
        do_req(1'b0, 3'b011, 32'h10, '0, lat, d, e);
        chk_eq("ld011_word", d, 32'h8000_00F0);

        repeat (3) @(negedge clk_i);
        chk_eq("rdata_hold", resp_data_o, 32'h8000_00F0);

        // Sub-word stores via read-modify-write
        r0 = reads; w0 = writes;
        do_req(1'b1, 3'b000, 32'h21, 32'h0000_00AB, lat, d, e);
        chk_eq("sb_mem", mem[8], 32'h1122_AB44);
        chk_eq("sb_reads", 32'(reads - r0), 32'd1);
        chk_eq("sb_writes", 32'(writes - w0), 32'd1);
        chk_eq("sb_rdata", d, 32'd0);
        chk_eq("sb_lat", 32'(lat), 32'd4);
        do_req(1'b1, 3'b001, 32'h22, 32'hFFFF_5566, lat, d, e);
        chk_eq("sh_mem", mem[8], 32'h5566_AB44);

        do_req(1'b0, 3'b010, 32'h22, '0, lat, d, e);
`ifdef LSU_MISALIGN_TRAP_EN
        chk_eq("lw22_err", 32'(e), 32'd1);
        chk_eq("lw22_data", d, 32'd0);
        chk_eq("lw22_lat", 32'(lat), 32'd2);
        rc0 = re_cycles;
        do_req(1'b0, 3'b010, 32'h22, '0, lat, d, e);
        chk_eq("lw22_nostrobe", 32'(re_cycles - rc0), 32'd0);
`else
        chk_eq("lw22_data", d, 32'h5566_AB44);
        chk_eq("lw22_err", 32'(e), 32'd0);
`endif

        // Word store with three wait cycles
        ack_delay = 3;
        wc0 = we_cycles;
        do_req(1'b1, 3'b010, 32'h30, 32'hDEAD_BEEF, lat, d, e);
        chk_eq("sw_we_cycles", 32'(we_cycles - wc0), 32'd4);
        chk_eq("sw_mem", mem[12], 32'hDEAD_BEEF);
        chk_eq("sw_lat", 32'(lat), 32'd6);
        chk_eq("sw_rdata", d, 32'd0);
        ack_delay = 0;

        // Back-to-back: valid held across LW then SW
        @(negedge clk_i);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h30;
        req_wdata_i = '0;
        @(posedge clk_i);
        #1 req_we_i = 1'b1; req_wdata_i = 32'h0BAD_F00D;
        resp_seen = 0; early_ready = 0; d = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (resp_valid_o) begin resp_seen = 1; d = resp_data_o; end
            if (req_ready_o) begin
                if (!resp_seen) early_ready++;
                break;
            end
        end
        chk_eq("b2b_lw_data", d, 32'hDEAD_BEEF);
        chk_eq("b2b_early_ready", 32'(early_ready), 32'd0);
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        resp_seen = 0;
        for (int i = 0; i < 30 && !resp_seen; i++) begin
            @(negedge clk_i);
            if (resp_valid_o) resp_seen = 1;
        end
        chk_eq("b2b_sw_resp", 32'(resp_seen), 32'd1);
        chk_eq("b2b_sw_mem", mem[12], 32'h0BAD_F00D);

        // Reset while a read waits for its ack
        ack_delay = 10;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h10;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk_eq("rmid_re_before", 32'(mem_re_o), 32'd1);
        #2 rst_i = 1'b0;
        #1;
        chk_eq("rmid_re",    32'(mem_re_o),    32'd0);
        chk_eq("rmid_we",    32'(mem_we_o),    32'd0);
        chk_eq("rmid_busy",  32'(busy_o),      32'd0);
        chk_eq("rmid_ready", 32'(req_ready_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 chk_eq("rmid_ready_rel", 32'(req_ready_o), 32'd1);
        resp_cnt = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (resp_valid_o) resp_cnt++;
        end
        chk_eq("rmid_no_resp", 32'(resp_cnt), 32'd0);
        ack_delay = 0;

        chk_eq("never_re_we", 32'(overlap), 32'd0);
        chk_eq("we_stable", 32'(unstable), 32'd0);
        chk_eq("busy_held", 32'(busy_gap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
